// File: rtl/tlc_pkg.sv
// Shared definitions for the parametrised traffic light controller.
//   LT_RED/LT_YELLOW/LT_GREEN : 2-bit signal head encoding
//   phase_e                   : FSM state type; codes are visible on the phase port
//   t_or_1                    : maps a zero duration to one tick
package tlc_pkg;

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_GREEN  = 2'b10;

    typedef enum logic [3:0] {
        AR_A  = 4'd0,
        NS_LT = 4'd1,
        NS_G  = 4'd2,
        NS_Y  = 4'd3,
        AR_B  = 4'd4,
        WALK  = 4'd5,
        EW_LT = 4'd6,
        EW_G  = 4'd7,
        EW_Y  = 4'd8,
        EMERG = 4'd9
    } phase_e;

    // A phase must last at least one tick, so a zero duration becomes one.
    function automatic int unsigned t_or_1(input int unsigned x);
        if (x == 32'd0) begin
            t_or_1 = 32'd1;
        end else begin
            t_or_1 = x;
        end
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase down-counter for the traffic light controller.
//   clk, reset : clock and asynchronous active-low reset
//   tick       : count enable
//   load       : reload with load_val (takes priority over counting)
//   load_val   : duration of the phase being entered, in ticks
//   done       : last tick of the current phase (count==1 and tick)
module tlc_phase_timer #(
    parameter int unsigned      CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = CNT_W'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_r;

    // Counter: reload on phase entry, otherwise count down on tick, holding at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= RST_VAL;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (tick && (cnt_r != CNT_W'(0))) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = tick && (cnt_r == CNT_W'(1));

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// Four-way intersection controller with timed phases, demand-driven
// protected lefts, a latched pedestrian walk phase and optional emergency
// preemption (enabled by defining EMERG_PREEMPT_EN).
//   clk, reset            : clock and asynchronous active-low reset
//   tick                  : phase-timer enable; state only advances on tick
//   ns_left_req/ew_left_req : left-turn demand levels
//   ped_req               : pedestrian button, latched internally
//   emerg_req/emerg_dir   : preemption request and direction (0=NS, 1=EW)
//   ns_light/ew_light     : signal heads (00 red, 01 yellow, 10 green)
//   ns_left/ew_left       : protected-left arrows
//   ped_walk              : walk indication
//   phase                 : current state code
module traffic_light_ctrl_param
    import tlc_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned GREEN_T  = 20,
    parameter int unsigned YELLOW_T = 4,
    parameter int unsigned LEFT_T   = 8,
    parameter int unsigned ALLRED_T = 2,
    parameter int unsigned WALK_T   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ns_left_req,
    input  logic       ew_left_req,
    input  logic       ped_req,
    input  logic       emerg_req,
    input  logic       emerg_dir,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       ns_left,
    output logic       ew_left,
    output logic       ped_walk,
    output logic [3:0] phase
);

    localparam logic [CNT_W-1:0] GREEN_L  = CNT_W'(t_or_1(GREEN_T));
    localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(t_or_1(YELLOW_T));
    localparam logic [CNT_W-1:0] LEFT_L   = CNT_W'(t_or_1(LEFT_T));
    localparam logic [CNT_W-1:0] ALLRED_L = CNT_W'(t_or_1(ALLRED_T));
    localparam logic [CNT_W-1:0] WALK_L   = CNT_W'(t_or_1(WALK_T));

    phase_e           state_r;
    phase_e           state_next_s;
    logic [CNT_W-1:0] load_val_s;
    logic             load_s;
    logic             done_s;
    logic             emerg_s;
    logic             preempt_s;
    logic             ped_latch_r;
    logic             enter_walk_s;
    logic             emerg_dir_r;
    logic             emerg_exit_r;
    logic             dir_next_s;
    logic [1:0]       ns_light_s;
    logic [1:0]       ew_light_s;
    logic             ns_left_s;
    logic             ew_left_s;
    logic             ped_walk_s;

`ifdef EMERG_PREEMPT_EN
    assign emerg_s = emerg_req;
`else
    // Preemption is compiled out; the request input is deliberately unused.
    logic unused_emerg_s;
    assign unused_emerg_s = emerg_req;
    assign emerg_s        = 1'b0;
`endif

    // Preemption only acts on tick edges so that tick=0 freezes everything.
    assign preempt_s    = tick && emerg_s;
    assign load_s       = (state_next_s != state_r);
    assign enter_walk_s = (state_next_s == WALK) && (state_r != WALK);
    assign phase        = state_r;

    tlc_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_L)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (load_s),
        .load_val (load_val_s),
        .done     (done_s)
    );

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            AR_A: begin
                if (done_s) begin
                    if (emerg_s)          state_next_s = EMERG;
                    else if (ns_left_req) state_next_s = NS_LT;
                    else                  state_next_s = NS_G;
                end else begin
                    state_next_s = state_r;
                end
            end
            NS_LT: begin
                if (preempt_s)   state_next_s = AR_B;
                else if (done_s) state_next_s = NS_G;
                else             state_next_s = state_r;
            end
            NS_G: begin
                if (preempt_s || done_s) state_next_s = NS_Y;
                else                     state_next_s = state_r;
            end
            NS_Y: begin
                // After an NS emergency hold the yellow returns to the start of the cycle.
                if (done_s) state_next_s = emerg_exit_r ? AR_A : AR_B;
                else        state_next_s = state_r;
            end
            AR_B: begin
                if (done_s) begin
                    if (emerg_s)          state_next_s = EMERG;
                    else if (ped_latch_r) state_next_s = WALK;
                    else if (ew_left_req) state_next_s = EW_LT;
                    else                  state_next_s = EW_G;
                end else begin
                    state_next_s = state_r;
                end
            end
            WALK: begin
                if (preempt_s)   state_next_s = AR_B;
                else if (done_s) state_next_s = ew_left_req ? EW_LT : EW_G;
                else             state_next_s = state_r;
            end
            EW_LT: begin
                if (preempt_s)   state_next_s = AR_A;
                else if (done_s) state_next_s = EW_G;
                else             state_next_s = state_r;
            end
            EW_G: begin
                if (preempt_s || done_s) state_next_s = EW_Y;
                else                     state_next_s = state_r;
            end
            EW_Y: begin
                if (done_s) state_next_s = AR_A;
                else        state_next_s = state_r;
            end
            EMERG: begin
                if (tick && !emerg_s) state_next_s = emerg_dir_r ? EW_Y : NS_Y;
                else                  state_next_s = state_r;
            end
            default: state_next_s = AR_A;
        endcase
    end

    // Duration loaded into the timer for the state being entered.
    always_comb begin
        load_val_s = ALLRED_L;
        case (state_next_s)
            NS_LT, EW_LT: load_val_s = LEFT_L;
            NS_G,  EW_G:  load_val_s = GREEN_L;
            NS_Y,  EW_Y:  load_val_s = YELLOW_L;
            WALK:         load_val_s = WALK_L;
            default:      load_val_s = ALLRED_L;
        endcase
    end

    // Output decode of the upcoming state so outputs change with the state register.
    always_comb begin
        ns_light_s = LT_RED;
        ew_light_s = LT_RED;
        ns_left_s  = 1'b0;
        ew_left_s  = 1'b0;
        ped_walk_s = 1'b0;
        if ((state_next_s == EMERG) && (state_r != EMERG)) begin
            dir_next_s = emerg_dir;
        end else begin
            dir_next_s = emerg_dir_r;
        end
        case (state_next_s)
            NS_LT: ns_left_s  = 1'b1;
            NS_G:  ns_light_s = LT_GREEN;
            NS_Y:  ns_light_s = LT_YELLOW;
            WALK:  ped_walk_s = 1'b1;
            EW_LT: ew_left_s  = 1'b1;
            EW_G:  ew_light_s = LT_GREEN;
            EW_Y:  ew_light_s = LT_YELLOW;
            EMERG: begin
                if (dir_next_s) ew_light_s = LT_GREEN;
                else            ns_light_s = LT_GREEN;
            end
            default: ns_light_s = LT_RED;
        endcase
    end

    // State, emergency bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= AR_A;
            emerg_dir_r  <= 1'b0;
            emerg_exit_r <= 1'b0;
            ns_light     <= LT_RED;
            ew_light     <= LT_RED;
            ns_left      <= 1'b0;
            ew_left      <= 1'b0;
            ped_walk     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            emerg_dir_r <= dir_next_s;
            // Remember that the coming yellow ends an emergency hold.
            if ((state_r == EMERG) && (state_next_s != EMERG)) begin
                emerg_exit_r <= 1'b1;
            end else if (((state_r == NS_Y) || (state_r == EW_Y)) && load_s) begin
                emerg_exit_r <= 1'b0;
            end else begin
                emerg_exit_r <= emerg_exit_r;
            end
            ns_light <= ns_light_s;
            ew_light <= ew_light_s;
            ns_left  <= ns_left_s;
            ew_left  <= ew_left_s;
            ped_walk <= ped_walk_s;
        end
    end

    // Pedestrian latch: a new press wins over the clear on WALK entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_latch_r <= 1'b0;
        end else begin
            ped_latch_r <= ped_req || (ped_latch_r && !enter_walk_s);
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
module tb_traffic_light_ctrl_param;

    localparam int P_AR_A = 0, P_NS_LT = 1, P_NS_G = 2, P_NS_Y = 3, P_AR_B = 4;
    localparam int P_WALK = 5, P_EW_LT = 6, P_EW_G = 7, P_EW_Y = 8, P_EMERG = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       ns_left_req;
    logic       ew_left_req;
    logic       ped_req;
    logic       emerg_req;
    logic       emerg_dir;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       ns_left;
    logic       ew_left;
    logic       ped_walk;
    logic [3:0] phase;

    int total = 0;
    int bad   = 0;
    int div   = 1;
    int dir_exp = 0;

    traffic_light_ctrl_param #(
        .CNT_W(8), .GREEN_T(20), .YELLOW_T(4), .LEFT_T(8), .ALLRED_T(2), .WALK_T(10)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .ns_left_req(ns_left_req), .ew_left_req(ew_left_req), .ped_req(ped_req),
        .emerg_req(emerg_req), .emerg_dir(emerg_dir),
        .ns_light(ns_light), .ew_light(ew_light), .ns_left(ns_left), .ew_left(ew_left),
        .ped_walk(ped_walk), .phase(phase)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_ns(input int ph);
        if (ph == P_NS_G) return 2;
        if (ph == P_NS_Y) return 1;
        if (ph == P_EMERG && dir_exp == 0) return 2;
        return 0;
    endfunction

    function automatic int exp_ew(input int ph);
        if (ph == P_EW_G) return 2;
        if (ph == P_EW_Y) return 1;
        if (ph == P_EMERG && dir_exp == 1) return 2;
        return 0;
    endfunction

    task automatic check_outs(input string tag, input int ph);
        chk({tag, " phase"},    {28'd0, phase},    ph);
        chk({tag, " ns_light"}, {30'd0, ns_light}, exp_ns(ph));
        chk({tag, " ew_light"}, {30'd0, ew_light}, exp_ew(ph));
        chk({tag, " ns_left"},  {31'd0, ns_left},  (ph == P_NS_LT) ? 1 : 0);
        chk({tag, " ew_left"},  {31'd0, ew_left},  (ph == P_EW_LT) ? 1 : 0);
        chk({tag, " ped_walk"}, {31'd0, ped_walk}, (ph == P_WALK) ? 1 : 0);
    endtask

    // Called just after the edge entering phase ph; runs until the phase
    // changes and checks its length in clocks. ped_at/emerg_at give the
    // cycle index at which ped_req pulses / emerg_req rises (-1 = never).
    task automatic run_phase(input string tag, input int ph, input int cycles,
                             input int ped_at, input int emerg_at);
        int n;
        n = 0;
        check_outs(tag, ph);
        while (n < cycles + 8) begin
            tick    = (div <= 1) ? 1'b1 : ((n % div) == (div - 1));
            ped_req = (n == ped_at);
            if (n == emerg_at) emerg_req = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (phase !== ph[3:0]) break;
            check_outs(tag, ph);
        end
        ped_req = 1'b0;
        tick    = 1'b1;
        chk({tag, " duration"}, n, cycles);
    endtask

    initial begin
        reset = 1'b0; tick = 1'b1; ns_left_req = 1'b0; ew_left_req = 1'b0;
        ped_req = 1'b0; emerg_req = 1'b0; emerg_dir = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", P_AR_A);
        @(negedge clk);
        reset = 1'b1;

        // 1: base cycle, no requests
        run_phase("t1 ar_a", P_AR_A, 2, -1, -1);
        run_phase("t1 ns_g", P_NS_G, 20, -1, -1);
        run_phase("t1 ns_y", P_NS_Y, 4, -1, -1);
        run_phase("t1 ar_b", P_AR_B, 2, -1, -1);
        run_phase("t1 ew_g", P_EW_G, 20, -1, -1);
        run_phase("t1 ew_y", P_EW_Y, 4, -1, -1);

        // 2: left-turn demand in both directions
        ns_left_req = 1'b1;
        ew_left_req = 1'b1;
        run_phase("t2 ar_a", P_AR_A, 2, -1, -1);
        run_phase("t2 ns_lt", P_NS_LT, 8, -1, -1);
        ns_left_req = 1'b0;
        run_phase("t2 ns_g", P_NS_G, 20, -1, -1);
        run_phase("t2 ns_y", P_NS_Y, 4, -1, -1);
        run_phase("t2 ar_b", P_AR_B, 2, -1, -1);
        run_phase("t2 ew_lt", P_EW_LT, 8, -1, -1);
        ew_left_req = 1'b0;
        run_phase("t2 ew_g", P_EW_G, 20, -1, -1);
        run_phase("t2 ew_y", P_EW_Y, 4, -1, -1);

        // 3: pedestrian pulse in NS_G, second pulse on the WALK entry cycle
        run_phase("t3 ar_a", P_AR_A, 2, -1, -1);
        run_phase("t3 ns_g", P_NS_G, 20, 5, -1);
        run_phase("t3 ns_y", P_NS_Y, 4, -1, -1);
        run_phase("t3 ar_b", P_AR_B, 2, 1, -1);
        run_phase("t3 walk", P_WALK, 10, -1, -1);
        run_phase("t3 ew_g", P_EW_G, 20, -1, -1);
        run_phase("t3 ew_y", P_EW_Y, 4, -1, -1);
        run_phase("t3 ar_a2", P_AR_A, 2, -1, -1);
        run_phase("t3 ns_g2", P_NS_G, 20, -1, -1);
        run_phase("t3 ns_y2", P_NS_Y, 4, -1, -1);
        run_phase("t3 ar_b2", P_AR_B, 2, -1, -1);
        run_phase("t3 walk2", P_WALK, 10, -1, -1);
        run_phase("t3 ew_g2", P_EW_G, 20, -1, -1);
        run_phase("t3 ew_y2", P_EW_Y, 4, -1, -1);
        run_phase("t3 ar_a3", P_AR_A, 2, -1, -1);
        run_phase("t3 ns_g3", P_NS_G, 20, -1, -1);
        run_phase("t3 ns_y3", P_NS_Y, 4, -1, -1);
        run_phase("t3 ar_b3", P_AR_B, 2, -1, -1);
        run_phase("t3 ew_g3", P_EW_G, 20, -1, -1);
        run_phase("t3 ew_y3", P_EW_Y, 4, -1, -1);

        // 4: tick one cycle in four
        div = 4;
        run_phase("t4 ar_a", P_AR_A, 8, -1, -1);
        run_phase("t4 ns_g", P_NS_G, 80, -1, -1);
        run_phase("t4 ns_y", P_NS_Y, 16, -1, -1);
        run_phase("t4 ar_b", P_AR_B, 8, -1, -1);
        check_outs("t4 ew_g", P_EW_G);
        for (int i = 0; i < 10; i++) begin
            tick = ((i % 4) == 3);
            @(posedge clk);
            #1;
            check_outs("t4 ew_g hold", P_EW_G);
        end

        // 5: asynchronous reset between clock edges
        #2;
        reset = 1'b0;
        #1;
        check_outs("t5 async reset", P_AR_A);
        tick = 1'b1;
        div  = 1;
        repeat (2) @(posedge clk);
        #1;
        check_outs("t5 held reset", P_AR_A);
        @(negedge clk);
        reset = 1'b1;
        run_phase("t5 ar_a", P_AR_A, 2, -1, -1);

        // 6: emergency request EW during NS_G tick 5
        emerg_dir = 1'b1;
`ifdef EMERG_PREEMPT_EN
        run_phase("t6 ns_g", P_NS_G, 5, -1, 4);
        run_phase("t6 ns_y", P_NS_Y, 4, -1, -1);
        run_phase("t6 ar_b", P_AR_B, 2, -1, -1);
        dir_exp = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_outs("t6 emerg hold", P_EMERG);
        end
        emerg_req = 1'b0;
        run_phase("t6 emerg", P_EMERG, 1, -1, -1);
        run_phase("t6 ew_y", P_EW_Y, 4, -1, -1);
        run_phase("t6 ar_a", P_AR_A, 2, -1, -1);
        check_outs("t6 ns_g", P_NS_G);
`else
        run_phase("t6 ns_g", P_NS_G, 20, -1, 4);
        run_phase("t6 ns_y", P_NS_Y, 4, -1, -1);
        run_phase("t6 ar_b", P_AR_B, 2, -1, -1);
        run_phase("t6 ew_g", P_EW_G, 20, -1, -1);
        emerg_req = 1'b0;
        run_phase("t6 ew_y", P_EW_Y, 4, -1, -1);
        check_outs("t6 ar_a", P_AR_A);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
